// File: rtl/fixed_latency_collector.sv
// Valid/ready front end for a fixed-latency go/done arithmetic unit with a credit-guarded result FIFO.
// Optional done-vs-go consistency checker enabled by defining FIXED_LATENCY_COLLECTOR_CHECK_EN.
module fixed_latency_collector #(
  parameter int unsigned LATENCY = 14,
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned DEPTH   = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [WIDTH-1:0]             req_a,
  input  logic [WIDTH-1:0]             req_b,
  output logic                         unit_go,
  output logic [WIDTH-1:0]             unit_a,
  output logic [WIDTH-1:0]             unit_b,
  input  logic                         unit_done,
  input  logic [WIDTH-1:0]             unit_result,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic [WIDTH-1:0]             resp_data,
  output logic [$clog2(DEPTH+1)-1:0]   in_flight,
  output logic                         err
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned FW = $clog2(LATENCY + 1);

  localparam logic [0:0] FLUSH = 1'b0;
  localparam logic [0:0] RUN   = 1'b1;

  logic [0:0]       state;
  logic [FW-1:0]    flush_cnt;
  logic [CW-1:0]    count;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  logic             running;
  logic             fire;
  logic             push;
  logic             pop;
  logic [CW:0]      credit_used;

  assign running     = (state == RUN);
  // Credit is computed from registered occupancy only, so a same-cycle pop never opens a slot early.
  assign credit_used = {1'b0, in_flight} + {1'b0, count};
  assign req_ready   = !reset && running && (credit_used < (CW + 1)'(DEPTH));
  assign fire        = req_valid && req_ready;
  assign unit_go     = fire;
  assign unit_a      = req_a;
  assign unit_b      = req_b;

  // A done with nothing outstanding is spurious and is dropped.
  assign push        = running && unit_done && (in_flight != '0);
  assign resp_valid  = (count != '0);
  assign pop         = resp_valid && resp_ready;
  assign resp_data   = mem[rd_ptr];

  // FLUSH spans exactly LATENCY cycles: the counter hits zero on the edge that enters RUN.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= FLUSH;
      flush_cnt <= FW'(LATENCY);
    end else if (state == FLUSH) begin
      flush_cnt <= flush_cnt - FW'(1);
      if (flush_cnt == FW'(1)) begin
        state <= RUN;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      in_flight <= '0;
    end else if (running) begin
      case ({fire, push})
        2'b10:   in_flight <= in_flight + CW'(1);
        2'b01:   in_flight <= in_flight - CW'(1);
        default: in_flight <= in_flight;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= unit_result;
    end
  end

`ifdef FIXED_LATENCY_COLLECTOR_CHECK_EN
  logic [LATENCY-1:0] go_hist;
  logic               err_q;

  // go_hist[LATENCY-1] is high exactly in the cycle a done is owed for an earlier go.
  always_ff @(posedge clock) begin
    if (reset) begin
      go_hist <= '0;
      err_q   <= 1'b0;
    end else begin
      go_hist <= (go_hist << 1) | LATENCY'(fire);
      if (running && (unit_done != go_hist[LATENCY-1])) begin
        err_q <= 1'b1;
`ifndef SYNTHESIS
        $display("fixed_latency_collector: done/go disagreement at time %0t (done=%0b expected=%0b)",
                 $time, unit_done, go_hist[LATENCY-1]);
`endif
      end
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: doc/fixed_latency_collector.md
# fixed_latency_collector

Requester-side companion to the fixed-latency pipelined arithmetic units (FP divide, sqrt, etc.) that use a one-bit go trigger in and a one-bit done trigger out. It converts a valid/ready request stream into go pulses toward the unit. It captures each done pulse and its result into a FIFO and presents them as a valid/ready response stream. Credit accounting guarantees the FIFO never overflows, since the unit itself cannot be stalled.

## Interface
- LATENCY, 14, cycles from unit_go to unit_done; must match the attached unit, ≥1
- WIDTH, 32, operand/result width
- DEPTH, 16, result FIFO entries; power of two, ≥2
- clock  in  1  sole clock, all state on rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  request offered
- req_ready  out  1  request accepted this cycle if req_valid
- req_a  in  WIDTH  operand A
- req_b  in  WIDTH  operand B
- unit_go  out  1  go trigger to unit
- unit_a  out  WIDTH  operand A to unit (passthrough of req_a)
- unit_b  out  WIDTH  operand B to unit (passthrough of req_b)
- unit_done  in  1  done trigger from unit
- unit_result  in  WIDTH  result from unit, valid with unit_done
- resp_valid  out  1  FIFO non-empty
- resp_ready  in  1  consumer takes head
- resp_data  out  WIDTH  FIFO head
- in_flight  out  clog2(DEPTH+1)  requests issued, done not yet seen
- err  out  1  sticky protocol error (see Configuration)

## Operation
- State machine, two states:
  - FLUSH: entered on reset. A counter loads LATENCY and decrements each cycle. Exit to RUN when the counter reaches 0, so FLUSH lasts exactly LATENCY cycles.
  - RUN: normal operation.
- In FLUSH: req_ready=0, and unit_done is ignored. This drains stale results from an un-reset unit pipeline.
- Credit rule: req_ready = (state==RUN) && (in_flight + fifo_count < DEPTH).
  - The sum uses registered values only.
  - A same-cycle pop does not raise req_ready.
- fire = req_valid && req_ready. unit_go = fire, combinational.
- unit_a/unit_b are driven from req_a/req_b combinationally every cycle.
- in_flight update per cycle, in RUN: +1 on fire, −1 on unit_done; both in the same cycle leaves it unchanged.
- unit_done in RUN writes unit_result at the FIFO tail, with count +1.
- Pop when resp_valid && resp_ready, with count −1.
  - Simultaneous push and pop: count unchanged, and the pointers both advance.
  - Push into an empty FIFO is not bypassed: resp_valid rises the next cycle.
- unit_done in RUN with in_flight==0 is a spurious done:
  - the result is dropped;
  - in_flight is not decremented (it saturates at 0);
  - the FIFO is not written.
- FIFO pointers are log2(DEPTH) bits and wrap naturally. count is clog2(DEPTH+1) bits.
- Reset values: req_ready=0, unit_go=0, resp_valid=0, in_flight=0, err=0, FIFO count/pointers=0, state=FLUSH. resp_data is don't-care while resp_valid=0.
- Reset mid-operation: all outstanding credits and FIFO contents are discarded, and the block re-enters FLUSH.

## Timing
- Fire at cycle t → unit_go high at t → unit_done at t+LATENCY → resp_valid/resp_data at t+LATENCY+1.
- Throughput: one request per cycle while credit is available.
- Steady state with resp_ready=1 constantly: throughput is one request per cycle and never throttles, provided DEPTH ≥ LATENCY+2.
- The first req_ready after reset deasserts is at cycle LATENCY following the last reset cycle.
- Responses leave in issue order, because the unit is in-order with fixed latency.

## Configuration
- FIXED_LATENCY_COLLECTOR_CHECK_EN defined:
  - A LATENCY-deep shift register tracks issued go pulses.
  - err is set, sticky until reset, when unit_done disagrees with the shift register output in RUN. This covers a missing done, an early done, and a spurious done.
  - The simulation-only $display reports the mismatch cycle.
- Macro undefined: the shift register is not built, err is tied to 0, and the drop behaviour for spurious dones is unchanged.

## Test plan
- Reset released, req_valid=1 held → req_ready=0 for 14 cycles, then one fire per cycle; first resp_valid exactly 15 cycles after first fire, resp_data equals model result.
- Back-to-back 100 requests with resp_ready=1, DEPTH=16 → no stall after FLUSH, 100 responses in order, in_flight peaks at 14.
- resp_ready=0 throughout, continuous requests → exactly 16 fires, then req_ready=0; FIFO count reaches 16 with no overwrite. Raising resp_ready for one cycle → one pop; req_ready returns the following cycle.
- Reset asserted with 5 in flight and 3 in FIFO → resp_valid=0 and in_flight=0 next cycle; stale unit_done pulses during FLUSH produce no response.
- Inject unit_done with in_flight==0 in RUN → no FIFO write, in_flight stays 0. err=1 with FIXED_LATENCY_COLLECTOR_CHECK_EN; err=0 without it.
